// File: rtl/mem_arbiter.sv
// Slotted SRAM arbiter: one access per 4-cycle slot, shared by video, CPU and DMA.
// Video has top priority. DMA overtakes the CPU after DMA_MAX_WAIT lost slots.
module mem_arbiter #(
  parameter int unsigned DMA_MAX_WAIT = 8
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        vid_req,
  input  logic [17:0] vid_addr,
  output logic        vid_ack,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [17:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_wait,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [17:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  rdata,
  output logic [17:0] ram_a,
  output logic [7:0]  ram_do,
  output logic        ram_doe,
  output logic        ram_n_oe,
  output logic        ram_n_we,
  input  logic [7:0]  ram_di
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_e;

  owner_e      owner_q, owner_d, gnt_s;
  logic [1:0]  phase_q, phase_d;
  logic        wr_q, wr_d;
  logic [3:0]  starve_q, starve_d;
  logic        cpu_wait_q, cpu_wait_d;
  logic        vid_ack_q, vid_ack_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dma_ack_q, dma_ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [17:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_do_q, ram_do_d;
  logic        ram_doe_q, ram_doe_d;
  logic        ram_n_oe_q, ram_n_oe_d;
  logic        ram_n_we_q, ram_n_we_d;
  logic        dma_prio_s;
  logic [17:0] gnt_addr_s;
  logic        gnt_wr_s;
  logic [7:0]  gnt_wdata_s;

  // Grant selection, sampled by the state update only at a P0 edge
  always_comb begin
    dma_prio_s  = (32'(starve_q) >= DMA_MAX_WAIT);
    gnt_s       = OWN_NONE;
    gnt_addr_s  = ram_a_q;
    gnt_wr_s    = 1'b0;
    gnt_wdata_s = ram_do_q;
    if (vid_req) begin
      gnt_s = OWN_VID;
    end else if (dma_req && dma_prio_s) begin
      gnt_s = OWN_DMA;
    end else if (cpu_req) begin
      gnt_s = OWN_CPU;
    end else if (dma_req) begin
      gnt_s = OWN_DMA;
    end else begin
      gnt_s = OWN_NONE;
    end
    case (gnt_s)
      OWN_VID: begin
        gnt_addr_s = vid_addr;
        gnt_wr_s   = 1'b0;
      end
      OWN_CPU: begin
        gnt_addr_s  = cpu_addr;
        gnt_wr_s    = cpu_wr;
        gnt_wdata_s = cpu_wdata;
      end
      OWN_DMA: begin
        gnt_addr_s  = dma_addr;
        gnt_wr_s    = dma_wr;
        gnt_wdata_s = dma_wdata;
      end
      default: begin
        gnt_addr_s = ram_a_q;
        gnt_wr_s   = 1'b0;
      end
    endcase
  end

  // Slot sequencing: strobes, ack and read capture per phase
  always_comb begin
    phase_d    = phase_q + 2'd1;
    owner_d    = owner_q;
    wr_d       = wr_q;
    starve_d   = starve_q;
    cpu_wait_d = cpu_wait_q;
    vid_ack_d  = 1'b0;
    cpu_ack_d  = 1'b0;
    dma_ack_d  = 1'b0;
    rdata_d    = rdata_q;
    ram_a_d    = ram_a_q;
    ram_do_d   = ram_do_q;
    ram_doe_d  = ram_doe_q;
    ram_n_oe_d = ram_n_oe_q;
    ram_n_we_d = ram_n_we_q;
    case (phase_q)
      2'd0: begin
        owner_d  = gnt_s;
        ram_a_d  = gnt_addr_s;
        wr_d     = gnt_wr_s;
        ram_do_d = gnt_wdata_s;
        if (gnt_s != OWN_NONE) begin
          ram_doe_d  = gnt_wr_s;
          ram_n_oe_d = gnt_wr_s;
          ram_n_we_d = ~gnt_wr_s;
        end else begin
          ram_doe_d  = 1'b0;
          ram_n_oe_d = 1'b1;
          ram_n_we_d = 1'b1;
        end
        cpu_wait_d = cpu_req && (gnt_s != OWN_CPU);
        if (dma_req && (gnt_s != OWN_DMA)) begin
          if (starve_q != 4'd15) begin
            starve_d = starve_q + 4'd1;
          end else begin
            starve_d = starve_q;
          end
        end else begin
          starve_d = 4'd0;
        end
      end
      2'd1: begin
        ram_n_we_d = ram_n_we_q;
      end
      2'd2: begin
        ram_n_we_d = 1'b1;
      end
      2'd3: begin
        ram_n_oe_d = 1'b1;
        vid_ack_d  = (owner_q == OWN_VID);
        cpu_ack_d  = (owner_q == OWN_CPU);
        dma_ack_d  = (owner_q == OWN_DMA);
        if ((owner_q != OWN_NONE) && !wr_q) begin
          rdata_d = ram_di;
        end else begin
          rdata_d = rdata_q;
        end
      end
      default: begin
        phase_d = 2'd0;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      phase_q    <= 2'd0;
      owner_q    <= OWN_NONE;
      wr_q       <= 1'b0;
      starve_q   <= 4'd0;
      cpu_wait_q <= 1'b0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      dma_ack_q  <= 1'b0;
      rdata_q    <= 8'd0;
      ram_a_q    <= 18'd0;
      ram_do_q   <= 8'd0;
      ram_doe_q  <= 1'b0;
      ram_n_oe_q <= 1'b1;
      ram_n_we_q <= 1'b1;
    end else begin
      phase_q    <= phase_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      starve_q   <= starve_d;
      cpu_wait_q <= cpu_wait_d;
      vid_ack_q  <= vid_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      dma_ack_q  <= dma_ack_d;
      rdata_q    <= rdata_d;
      ram_a_q    <= ram_a_d;
      ram_do_q   <= ram_do_d;
      ram_doe_q  <= ram_doe_d;
      ram_n_oe_q <= ram_n_oe_d;
      ram_n_we_q <= ram_n_we_d;
    end
  end

  assign vid_ack  = vid_ack_q;
  assign cpu_ack  = cpu_ack_q;
  assign dma_ack  = dma_ack_q;
  assign cpu_wait = cpu_wait_q;
  assign rdata    = rdata_q;
  assign ram_a    = ram_a_q;
  assign ram_do   = ram_do_q;
  assign ram_doe  = ram_doe_q;
  assign ram_n_oe = ram_n_oe_q;
  assign ram_n_we = ram_n_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Cycle k is observed 1 ns after the k-th edge
// following a grant edge; the bench tracks slot phase itself from reset release.
module tb_mem_arbiter;

  logic        clk28, rst_n;
  logic        vid_req, cpu_req, cpu_wr, dma_req, dma_wr;
  logic [17:0] vid_addr, cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata, ram_di;
  logic        vid_ack, cpu_ack, cpu_wait, dma_ack;
  logic [7:0]  rdata, ram_do;
  logic [17:0] ram_a;
  logic        ram_doe, ram_n_oe, ram_n_we;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  mem_arbiter #(.DMA_MAX_WAIT(8)) dut (
    .clk28(clk28), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .rdata(rdata), .ram_a(ram_a), .ram_do(ram_do),
    .ram_doe(ram_doe), .ram_n_oe(ram_n_oe), .ram_n_we(ram_n_we), .ram_di(ram_di)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  task automatic step();
    @(posedge clk28);
    #1;
    cyc++;
  endtask

  // Advance until the next edge is a P0 (arbitration) edge.
  task automatic align();
    while (cyc % 4 != 0) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vid_req = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
    vid_addr = 18'h12345; cpu_addr = 18'h00abc; dma_addr = 18'h00def;
    cpu_wr = 1'b1; dma_wr = 1'b1; cpu_wdata = 8'hee; dma_wdata = 8'hdd; ram_di = 8'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if ({ram_n_oe, ram_n_we, ram_doe, vid_ack, cpu_ack, dma_ack, cpu_wait} !== 7'b1100000) begin
        tests_failed++;
        $display("FAIL reset_ctrl: got oe/we/doe/acks/wait=%b required 1100000",
                 {ram_n_oe, ram_n_we, ram_doe, vid_ack, cpu_ack, dma_ack, cpu_wait});
      end
      tests_run++;
      if (ram_a !== 18'h0 || rdata !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_data: got ram_a=%h rdata=%h required 0/0", ram_a, rdata);
      end
    end
    vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    cpu_wr = 1'b0; dma_wr = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_cpu_read();
    align();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 18'h04000; ram_di = 8'h5a;
    for (int k = 1; k <= 5; k++) begin
      step();
      tests_run++;
      if (ram_n_oe !== ((k >= 1 && k <= 3) ? 1'b0 : 1'b1)) begin
        tests_failed++;
        $display("FAIL rd_oe k=%0d: got %b required %b", k, ram_n_oe, (k <= 3) ? 1'b0 : 1'b1);
      end
      tests_run++;
      if (cpu_ack !== (k == 4) || ram_n_we !== 1'b1 || ram_doe !== 1'b0) begin
        tests_failed++;
        $display("FAIL rd_ack k=%0d: got ack=%b we=%b doe=%b required %b/1/0",
                 k, cpu_ack, ram_n_we, ram_doe, (k == 4));
      end
      tests_run++;
      if (ram_a !== 18'h04000) begin
        tests_failed++;
        $display("FAIL rd_addr k=%0d: got %h required 04000", k, ram_a);
      end
      if (k == 1) cpu_addr = 18'h3ffff;
      if (k == 3) ram_di = 8'ha5;
      if (k == 4) begin
        tests_run++;
        if (rdata !== 8'ha5) begin
          tests_failed++;
          $display("FAIL rd_data: got %h required a5", rdata);
        end
        ram_di = 8'h00;
        cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_cpu_write();
    align();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 18'h1ffff; cpu_wdata = 8'h3c; ram_di = 8'h77;
    for (int k = 1; k <= 5; k++) begin
      step();
      tests_run++;
      if (ram_n_we !== ((k == 1 || k == 2) ? 1'b0 : 1'b1) || ram_n_oe !== 1'b1) begin
        tests_failed++;
        $display("FAIL wr_we k=%0d: got we=%b oe=%b required %b/1",
                 k, ram_n_we, ram_n_oe, (k <= 2) ? 1'b0 : 1'b1);
      end
      tests_run++;
      if (ram_doe !== (k <= 4)) begin
        tests_failed++;
        $display("FAIL wr_doe k=%0d: got %b required %b", k, ram_doe, (k <= 4));
      end
      if (k <= 4) begin
        tests_run++;
        if (ram_do !== 8'h3c || ram_a !== 18'h1ffff) begin
          tests_failed++;
          $display("FAIL wr_data k=%0d: got do=%h a=%h required 3c/1ffff", k, ram_do, ram_a);
        end
      end
      tests_run++;
      if (cpu_ack !== (k == 4) || rdata !== 8'ha5) begin
        tests_failed++;
        $display("FAIL wr_ack k=%0d: got ack=%b rdata=%h required %b/a5", k, cpu_ack, rdata, (k == 4));
      end
      if (k == 1) begin cpu_wdata = 8'hff; cpu_addr = 18'h00001; end
      if (k == 4) begin cpu_req = 1'b0; cpu_wr = 1'b0; end
    end
  endtask

  task automatic test_vid_cpu();
    align();
    vid_req = 1'b1; vid_addr = 18'h00100;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 18'h00200;
    for (int k = 1; k <= 9; k++) begin
      step();
      tests_run++;
      if (vid_ack !== (k == 4) || cpu_ack !== (k == 8)) begin
        tests_failed++;
        $display("FAIL vc_ack k=%0d: got vid=%b cpu=%b required %b/%b", k, vid_ack, cpu_ack, (k == 4), (k == 8));
      end
      tests_run++;
      if (cpu_wait !== (k <= 4)) begin
        tests_failed++;
        $display("FAIL vc_wait k=%0d: got %b required %b", k, cpu_wait, (k <= 4));
      end
      if (k <= 8) begin
        tests_run++;
        if (ram_a !== ((k <= 4) ? 18'h00100 : 18'h00200)) begin
          tests_failed++;
          $display("FAIL vc_addr k=%0d: got %h required %h", k, ram_a, (k <= 4) ? 18'h00100 : 18'h00200);
        end
      end
      if (k == 3 || k == 7) ram_di = (k == 3) ? 8'h11 : 8'h22;
      if (k == 4 || k == 8) begin
        tests_run++;
        if (rdata !== ((k == 4) ? 8'h11 : 8'h22)) begin
          tests_failed++;
          $display("FAIL vc_rdata k=%0d: got %h required %h", k, rdata, (k == 4) ? 8'h11 : 8'h22);
        end
        if (k == 4) vid_req = 1'b0;
        else cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_dma_starve();
    logic is_dma;
    align();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 18'h00300;
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 18'h2aaaa; dma_wdata = 8'h5a;
    for (int s = 1; s <= 18; s++) begin
      is_dma = (s == 9 || s == 18);
      for (int c = 1; c <= 4; c++) begin
        step();
        if (c == 1) begin
          tests_run++;
          if (ram_a !== (is_dma ? 18'h2aaaa : 18'h00300) || ram_doe !== is_dma) begin
            tests_failed++;
            $display("FAIL starve_grant slot=%0d: got a=%h doe=%b required dma=%b", s, ram_a, ram_doe, is_dma);
          end
          tests_run++;
          if (cpu_wait !== is_dma) begin
            tests_failed++;
            $display("FAIL starve_wait slot=%0d: got %b required %b", s, cpu_wait, is_dma);
          end
        end
        if (c == 4) begin
          tests_run++;
          if (dma_ack !== is_dma || cpu_ack !== !is_dma) begin
            tests_failed++;
            $display("FAIL starve_ack slot=%0d: got dma=%b cpu=%b required %b/%b", s, dma_ack, cpu_ack, is_dma, !is_dma);
          end
          if (s == 18) begin cpu_req = 1'b0; dma_req = 1'b0; dma_wr = 1'b0; end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    align();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 18'h00055; cpu_wdata = 8'h99;
    step();
    step();
    tests_run++;
    if (ram_n_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_pre: got we=%b required 0", ram_n_we);
    end
    rst_n = 1'b0;
    step();
    tests_run++;
    if (ram_n_we !== 1'b1 || ram_doe !== 1'b0 || cpu_ack !== 1'b0 || ram_a !== 18'h0) begin
      tests_failed++;
      $display("FAIL rstmid_strobe: got we=%b doe=%b ack=%b a=%h required 1/0/0/0", ram_n_we, ram_doe, cpu_ack, ram_a);
    end
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      tests_run++;
      if (cpu_ack !== (k == 4) || ram_a !== 18'h00055) begin
        tests_failed++;
        $display("FAIL rstmid_regrant k=%0d: got ack=%b a=%h required %b/00055", k, cpu_ack, ram_a, (k == 4));
      end
      if (k == 1) begin
        tests_run++;
        if (ram_n_we !== 1'b0) begin
          tests_failed++;
          $display("FAIL rstmid_we: got %b required 0", ram_n_we);
        end
      end
      if (k == 4) begin cpu_req = 1'b0; cpu_wr = 1'b0; end
    end
  endtask

  task automatic test_withdraw();
    int acks;
    acks = 0;
    align();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 18'h00777; ram_di = 8'h3e;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) cpu_req = 1'b0;
      if (cpu_ack === 1'b1) acks++;
      tests_run++;
      if (cpu_ack !== (k == 4)) begin
        tests_failed++;
        $display("FAIL wd_ack k=%0d: got %b required %b", k, cpu_ack, (k == 4));
      end
      if (k >= 4) begin
        tests_run++;
        if (ram_n_oe !== 1'b1 || cpu_wait !== 1'b0) begin
          tests_failed++;
          $display("FAIL wd_idle k=%0d: got oe=%b wait=%b required 1/0", k, ram_n_oe, cpu_wait);
        end
      end
      if (k == 4) begin
        tests_run++;
        if (rdata !== 8'h3e) begin
          tests_failed++;
          $display("FAIL wd_rdata: got %h required 3e", rdata);
        end
      end
    end
    tests_run++;
    if (acks != 1) begin
      tests_failed++;
      $display("FAIL wd_count: got %0d acks required 1", acks);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    cpu_wr = 1'b0; dma_wr = 1'b0;
    vid_addr = 18'h0; cpu_addr = 18'h0; dma_addr = 18'h0;
    cpu_wdata = 8'h0; dma_wdata = 8'h0; ram_di = 8'h0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_vid_cpu();
    test_dma_starve();
    test_reset_mid();
    test_withdraw();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DMA_MAX_WAIT, default 8, meaning: lost slots after which a pending DMA request outranks the CPU.
REQ-002 clk28  input  1  system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 vid_req  input  1  video fetch request, level, held until vid_ack.
REQ-005 vid_addr  input  18  video fetch address.
REQ-006 vid_ack  output  1  one-cycle pulse; rdata holds video data.
REQ-007 cpu_req  input  1  CPU access request, level, held until cpu_ack.
REQ-008 cpu_wr  input  1  CPU access is a write when 1.
REQ-009 cpu_addr  input  18  CPU address.
REQ-010 cpu_wdata  input  8  CPU write data.
REQ-011 cpu_ack  output  1  one-cycle completion pulse for the CPU.
REQ-012 cpu_wait  output  1  CPU stall request, consumed by the CPU clock gate.
REQ-013 dma_req, dma_wr, dma_addr[17:0], dma_wdata[7:0]  input  DMA requester; same semantics as the CPU group.
REQ-014 dma_ack  output  1  one-cycle completion pulse for DMA.
REQ-015 rdata  output  8  read data latched from SRAM, valid while any ack is high.
REQ-016 ram_a  output  18  SRAM address.
REQ-017 ram_do  output  8  SRAM write data; ram_doe  output  1  data bus drive enable.
REQ-018 ram_n_oe, ram_n_we  output  1  SRAM strobes, active-low.
REQ-019 ram_di  input  8  SRAM read data.

Function
REQ-020 A free-running 2-bit phase counter shall divide time into 4-cycle slots, phases P0..P3, wrapping P3->P0.
REQ-021 Arbitration shall occur only at P0; requests rising at P1..P3 wait for the next P0.
REQ-022 Priority: video > CPU > DMA, except that DMA outranks the CPU when starve_cnt >= DMA_MAX_WAIT; video is never preempted.
REQ-023 With no request at P0, the slot shall be idle: ram_n_oe=1, ram_n_we=1, ram_doe=0, ram_a unchanged.
REQ-024 The granted address shall be registered onto ram_a at the P0 edge and held through P3.
REQ-025 Read slot: ram_n_oe low during P1..P3; rdata captured from ram_di at the end of P3.
REQ-026 Write slot: ram_doe and ram_do valid during P0..P3; ram_n_we low during P1..P2 only; rdata unchanged.
REQ-027 The granted requester's ack shall pulse for exactly one cycle, in the P0 cycle following its slot; latency from a P0 grant to ack is 4 cycles.
REQ-028 A requester that still holds req in its ack cycle shall be treated as a new request and may be regranted in that same P0.
REQ-029 A request withdrawn mid-slot shall not abort the access; the slot completes and the ack is still issued.
REQ-030 starve_cnt (4 bits): increments at each P0 where dma_req=1 and DMA is not granted; clears when DMA is granted or dma_req=0; saturates at 15.
REQ-031 cpu_wait shall be registered: 1 from the cycle after a P0 where cpu_req=1 and the CPU is not granted, until the CPU's grant P0; it is 0 while the CPU slot is in progress.
REQ-032 Simultaneous requests from all three sources shall grant video; CPU and DMA stay pending, and starve_cnt increments.
REQ-033 Write data and address shall be captured at grant; later changes on the requester inputs during the slot shall have no effect.

Reset
REQ-034 While rst_n=0 at a clock edge: phase=P0, no grant, all acks 0, cpu_wait 0, starve_cnt 0, rdata 0, ram_a 0, ram_n_oe=1, ram_n_we=1, ram_doe=0.
REQ-035 Reset asserted mid-slot shall deassert the strobes at the next edge and suppress that slot's ack; the first arbitration shall be the first P0 after rst_n=1.

Verification
REQ-036 CPU read of 0x04000, with ram_di=0xA5 at P3 -> ram_n_oe low for P1..P3, cpu_ack is one pulse at the next P0, and rdata=0xA5.
REQ-037 vid_req and cpu_req both asserted at the same P0 -> vid_ack at +4 cycles; the CPU is granted at that P0, cpu_ack at +8; cpu_wait=1 for cycles 1..4.
REQ-038 CPU write 0x3C to 0x1FFFF -> ram_n_we low exactly 2 cycles (P1, P2), ram_do=0x3C for P0..P3, rdata unchanged.
REQ-039 cpu_req held continuously with dma_req, DMA_MAX_WAIT=8 -> DMA is granted in the 9th slot; starve_cnt returns to 0.
REQ-040 rst_n pulled low in P2 of a write -> ram_n_we=1 at the next edge, no cpu_ack; after release the first grant occurs at P0.
REQ-041 cpu_req dropped at P1 of its slot -> the access completes and cpu_ack still pulses once; no regrant follows.
